mix_columns_seq: RTL and testbench

Sequential, parametrised AES MixColumns / InvMixColumns engine with valid/ready handshakes on input and output. It accepts one 128-bit AES state and transforms `COLS_PER_CYCLE` columns per clock over `4/COLS_PER_CYCLE` cycles. It then holds the result until the downstream stage takes it. It sits between the ShiftRows and AddRoundKey stages of the round datapath and supersedes the purely combinational column mixer.

---
 rtl/mix_columns_seq.sv | 145 ++++++++++++++
 tb/tb_mix_columns_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Define MIX_COLUMNS_INV_EN to build the inverse datapath; otherwise in_inv is ignored and every state gets forward MixColumns.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int STEPS = 4 / COLS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [127:0]   work_q, work_d;
    logic [CW-1:0]  cnt_q;
    logic           accept;
    logic           last_step;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One output row: 2p ^ 3q ^ r ^ s, rows obtained by rotating the column.
    function automatic logic [7:0] fwd_row(input logic [7:0] p, q, r, s);
        return xtime(p) ^ xtime(q) ^ q ^ r ^ s;
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        return {fwd_row(c[31:24], c[7:0],   c[15:8],  c[23:16]),
                fwd_row(c[23:16], c[31:24], c[7:0],   c[15:8]),
                fwd_row(c[15:8],  c[23:16], c[31:24], c[7:0]),
                fwd_row(c[7:0],   c[15:8],  c[23:16], c[31:24])};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    logic mode_q;

    // 0e.p ^ 0b.q ^ 0d.r ^ 09.s built from shared xtime chains.
    function automatic logic [7:0] inv_row(input logic [7:0] p, q, r, s);
        logic [7:0] p2, p4, p8, q2, q8, r4, r8, s8;
        p2 = xtime(p);  p4 = xtime(p2); p8 = xtime(p4);
        q2 = xtime(q);  q8 = xtime(xtime(q2));
        r4 = xtime(xtime(r)); r8 = xtime(r4);
        s8 = xtime(xtime(xtime(s)));
        return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (r8 ^ r4 ^ r) ^ (s8 ^ s);
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        return {inv_row(c[31:24], c[7:0],   c[15:8],  c[23:16]),
                inv_row(c[23:16], c[31:24], c[7:0],   c[15:8]),
                inv_row(c[15:8],  c[23:16], c[31:24], c[7:0]),
                inv_row(c[7:0],   c[15:8],  c[23:16], c[31:24])};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        return inv ? mix_inv(c) : mix_fwd(c);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         mode_q <= 1'b0;
        else if (accept) mode_q <= in_inv;
    end
`else
    logic unused_inv;
    assign unused_inv = in_inv;

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        return inv ? 32'h0 : mix_fwd(c);
    endfunction

    logic mode_q;
    assign mode_q = 1'b0;
`endif

    // Columns cnt*C .. cnt*C+C-1 are rewritten in place; the 2-bit cast folds cnt away when C=4.
    always_comb begin
        logic [1:0] col;
        col    = '0;
        work_d = work_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col = 2'(int'(cnt_q) * COLS_PER_CYCLE + j);
            work_d[{col, 5'b0} +: 32] = mix_col(work_q[{col, 5'b0} +: 32], mode_q);
        end
    end

    assign last_step = (cnt_q == CW'(STEPS - 1));
    assign accept    = in_valid && in_ready;
    assign out_data  = work_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            work_q <= in_data;
            cnt_q  <= '0;
        end else if (state_q == BUSY) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            BUSY: busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: one instance per COLS_PER_CYCLE (1, 2, 4), known AES vectors plus a gmul reference model.
module tb_mix_columns_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         in_inv    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_inv(in_inv[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_inv(in_inv[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .in_inv(in_inv[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

`ifdef MIX_COLUMNS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam logic [127:0] VEC   = 128'hC6C6C6C6_01010101_5C220AF2_455313DB;
    localparam logic [127:0] VEC_F = 128'hC6C6C6C6_01010101_9D58DC9F_BCA14D8E;

    int n_cmp = 0;
    int n_bad = 0;
    int lat [3];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] st, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   o;
        logic [127:0] res;
        if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
        else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int k = 0; k < 4; k++) o = o ^ gmul(st[32*c+8*k +: 8], cf[(k - r + 4) % 4]);
                res[32*c+8*r +: 8] = o;
            end
        return res;
    endfunction

    task automatic drive_in(input int i, input logic [127:0] d, input logic inv);
        in_valid[i] = 1'b1; in_data[i] = d; in_inv[i] = inv;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_valid(input int i, output int cycles);
        cycles = 0;
        while (!out_valid[i] && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid[i]) cycles = -1;
    endtask

    task automatic take(input int i);
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready[i] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready[i]); end
            n_cmp++; if (out_valid[i] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid[i]); end
            n_cmp++; if (busy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
            n_cmp++; if (out_data[i] !== 128'h0) begin n_bad++; $display("FAIL reset_out_data[%0d]: got %h want 0", i, out_data[i]); end
        end
    endtask

    task automatic test_forward;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            drive_in(i, VEC, 1'b0);
            n_cmp++; if (busy[i] !== 1'b1) begin n_bad++; $display("FAIL fwd_busy[%0d]: got %b want 1", i, busy[i]); end
            wait_valid(i, cyc);
            n_cmp++; if (cyc !== lat[i]) begin n_bad++; $display("FAIL fwd_latency[%0d]: got %0d want %0d", i, cyc, lat[i]); end
            n_cmp++; if (out_data[i] !== VEC_F) begin n_bad++; $display("FAIL fwd_data[%0d]: got %h want %h", i, out_data[i], VEC_F); end
            n_cmp++; if (in_ready[i] !== 1'b0) begin n_bad++; $display("FAIL fwd_done_in_ready[%0d]: got %b want 0", i, in_ready[i]); end
            take(i);
            n_cmp++; if (out_valid[i] !== 1'b0) begin n_bad++; $display("FAIL fwd_drop_valid[%0d]: got %b want 0", i, out_valid[i]); end
        end
    endtask

    task automatic test_inverse;
        int cyc;
        logic [127:0] exp;
        exp = INV_EN ? VEC : model_mix(VEC_F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_in(i, VEC_F, 1'b1);
            wait_valid(i, cyc);
            n_cmp++; if (cyc !== lat[i]) begin n_bad++; $display("FAIL inv_latency[%0d]: got %0d want %0d", i, cyc, lat[i]); end
            n_cmp++; if (out_data[i] !== exp) begin n_bad++; $display("FAIL inv_data[%0d]: got %h want %h", i, out_data[i], exp); end
            take(i);
        end
    endtask

    task automatic test_inv_toggle;
        int cyc;
        logic [127:0] exp;
        for (int m = 0; m < 2; m++) begin
            exp = (m == 1 && INV_EN) ? VEC : model_mix(VEC_F, 1'b0);
            drive_in(0, VEC_F, m[0]);
            in_data[0] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FFFF_0000;
            for (int t = 0; t < 3; t++) begin
                in_inv[0] = ~in_inv[0];
                @(posedge clk); #1;
            end
            wait_valid(0, cyc);
            n_cmp++; if (out_data[0] !== exp) begin n_bad++; $display("FAIL inv_toggle_data[m=%0d]: got %h want %h", m, out_data[0], exp); end
            take(0);
        end
        in_inv[0] = 1'b0;
    endtask

    task automatic test_fixed_points;
        int cyc;
        logic [127:0] pats [3];
        pats[0] = '0; pats[1] = {16{8'h01}}; pats[2] = {16{8'hC6}};
        for (int p = 0; p < 3; p++)
            for (int m = 0; m < 2; m++) begin
                drive_in(0, pats[p], m[0]);
                wait_valid(0, cyc);
                n_cmp++; if (out_data[0] !== pats[p]) begin n_bad++; $display("FAIL fixed_point[p=%0d m=%0d]: got %h want %h", p, m, out_data[0], pats[p]); end
                take(0);
            end
    endtask

    task automatic test_backpressure;
        int cyc;
        logic [127:0] exp2;
        exp2 = model_mix(VEC_F, 1'b0);
        drive_in(0, VEC, 1'b0);
        wait_valid(0, cyc);
        in_valid[0] = 1'b1; in_data[0] = VEC_F; in_inv[0] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_data[0] !== VEC_F || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
                n_bad++; $display("FAIL stall[%0d]: got data %h rdy %b vld %b want data %h rdy 0 vld 1", t, out_data[0], in_ready[0], out_valid[0], VEC_F);
            end
        end
        out_ready[0] = 1'b1;
        #1;
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready[0]); end
        @(posedge clk); #1;
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        n_cmp++; if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL same_cycle_accept: got busy %b vld %b want busy 1 vld 0", busy[0], out_valid[0]); end
        wait_valid(0, cyc);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL second_latency: got %0d want 4", cyc); end
        n_cmp++; if (out_data[0] !== exp2) begin n_bad++; $display("FAIL second_data: got %h want %h", out_data[0], exp2); end
        take(0);
    endtask

    task automatic test_reset_mid_busy;
        int cyc;
        int seen;
        drive_in(0, VEC, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready[0]); end
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid[0]); end
        n_cmp++; if (out_data[0] !== 128'h0) begin n_bad++; $display("FAIL midrst_out_data: got %h want 0", out_data[0]); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy[0]); end
        #1;
        rst = 1'b0;
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
        drive_in(0, VEC, 1'b0);
        wait_valid(0, cyc);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL postrst_latency: got %0d want 4", cyc); end
        n_cmp++; if (out_data[0] !== VEC_F) begin n_bad++; $display("FAIL postrst_data: got %h want %h", out_data[0], VEC_F); end
        take(0);
    endtask

    task automatic test_back_to_back;
        logic [127:0] d   [8];
        logic [127:0] exp [8];
        logic         iv  [8];
        logic         acc, ret;
        int k, got, cyc, last, gap;
        for (int n = 0; n < 8; n++) begin
            d[n]   = {$urandom, $urandom, $urandom, $urandom};
            iv[n]  = n[0];
            exp[n] = model_mix(d[n], iv[n] && INV_EN);
        end
        k = 0; got = 0; cyc = 0; last = -1; gap = 0;
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b1; in_data[0] = d[0]; in_inv[0] = iv[0];
        while (got < 8 && cyc < 200) begin
            acc = in_valid[0] && in_ready[0];
            ret = out_valid[0];
            if (ret) begin
                n_cmp++; if (out_data[0] !== exp[got]) begin n_bad++; $display("FAIL stream[%0d]: got %h want %h", got, out_data[0], exp[got]); end
                if (last >= 0) gap = cyc - last;
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                k++;
                if (k < 8) begin in_data[0] = d[k]; in_inv[0] = iv[k]; end
                else in_valid[0] = 1'b0;
            end
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", got); end
        n_cmp++; if (gap !== 5) begin n_bad++; $display("FAIL stream_period: got %0d want 5", gap); end
    endtask

    initial begin
        lat[0] = 4; lat[1] = 2; lat[2] = 1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; in_inv[i] = 1'b0; out_ready[i] = 1'b0;
        end
        @(posedge clk); #1;
        test_reset;
        rst = 1'b0;
        @(posedge clk); #1;
        test_forward;
        test_inverse;
        test_inv_toggle;
        test_fixed_points;
        test_backpressure;
        test_reset_mid_busy;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
